// File: rtl/pipe_hazard_unit.sv
// Hazard/forwarding controller beside the ID stage: a shift-register scoreboard of
// in-flight register writes drives operand bypass selects, stalls and branch flushes.
module pipe_hazard_unit #(
  parameter int RW       = 5,
  parameter int DEPTH    = 3,
  parameter int LOAD_LAT = 2,
  parameter int BR_STAGE = 3,
  parameter int FWD_EN   = 1,
  parameter int CW       = 16
) (
  input  logic                         clk,
  input  logic                         clr,
  input  logic                         id_valid,
  input  logic [RW-1:0]                id_rs,
  input  logic [RW-1:0]                id_rt,
  input  logic                         id_use_rs,
  input  logic                         id_use_rt,
  input  logic                         id_wreg,
  input  logic                         id_m2reg,
  input  logic [RW-1:0]                id_wn,
  input  logic                         br_taken,
  output logic                         stall,
  output logic                         bubble,
  output logic                         flush,
  output logic [$clog2(DEPTH+1)-1:0]   fwd_a,
  output logic [$clog2(DEPTH+1)-1:0]   fwd_b,
  output logic [CW-1:0]                stall_cnt,
  output logic [CW-1:0]                flush_cnt
);
  localparam int FW = $clog2(DEPTH + 1);

  logic          sb_valid_reg [1:DEPTH];
  logic [RW-1:0] sb_wn_reg    [1:DEPTH];
  logic          sb_m2reg_reg [1:DEPTH];

  logic [DEPTH:1] match_a;
  logic [DEPTH:1] match_b;
  logic [FW-1:0]  k_a;
  logic [FW-1:0]  k_b;
  logic           load_a;
  logic           load_b;
  logic           stall_a;
  logic           stall_b;
  logic           stall_any;
  logic [CW-1:0]  stall_cnt_reg;
  logic [CW-1:0]  flush_cnt_reg;

  genvar gi;
  generate
    for (gi = 1; gi <= DEPTH; gi++) begin : g_match
      assign match_a[gi] = id_valid && id_use_rs && (id_rs != '0) &&
                           sb_valid_reg[gi] && (sb_wn_reg[gi] == id_rs);
      assign match_b[gi] = id_valid && id_use_rt && (id_rt != '0) &&
                           sb_valid_reg[gi] && (sb_wn_reg[gi] == id_rt);
    end
  endgenerate

  // Scan oldest to youngest so the lowest matching entry is the one kept.
  always_comb begin
    k_a    = '0;
    k_b    = '0;
    load_a = 1'b0;
    load_b = 1'b0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (match_a[k]) begin
        k_a    = FW'(k);
        load_a = sb_m2reg_reg[k];
      end
      if (match_b[k]) begin
        k_b    = FW'(k);
        load_b = sb_m2reg_reg[k];
      end
    end
    stall_a   = (|match_a) && ((FWD_EN == 0) || (load_a && (int'(k_a) < LOAD_LAT)));
    stall_b   = (|match_b) && ((FWD_EN == 0) || (load_b && (int'(k_b) < LOAD_LAT)));
    stall_any = stall_a || stall_b;
    flush     = br_taken;
    stall     = stall_any && !br_taken;
    bubble    = stall_any || br_taken;
    fwd_a     = ((FWD_EN != 0) && !stall_a) ? k_a : '0;
    fwd_b     = ((FWD_EN != 0) && !stall_b) ? k_b : '0;
  end

  // Entries younger than the resolving branch are killed instead of advancing.
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int k = 1; k <= DEPTH; k++) sb_valid_reg[k] <= 1'b0;
    end else begin
      sb_valid_reg[1] <= id_valid && id_wreg && !stall_any && !br_taken;
      for (int k = 2; k <= DEPTH; k++)
        sb_valid_reg[k] <= sb_valid_reg[k-1] && !(br_taken && ((k - 1) < BR_STAGE));
    end
  end

  always_ff @(posedge clk) begin
    sb_wn_reg[1]    <= id_wn;
    sb_m2reg_reg[1] <= id_m2reg;
  end

  generate
    for (gi = 2; gi <= DEPTH; gi++) begin : g_shift
      always_ff @(posedge clk) begin
        sb_wn_reg[gi]    <= sb_wn_reg[gi-1];
        sb_m2reg_reg[gi] <= sb_m2reg_reg[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (clr) begin
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      if (stall && (stall_cnt_reg != '1)) stall_cnt_reg <= stall_cnt_reg + CW'(1);
      if (flush && (flush_cnt_reg != '1)) flush_cnt_reg <= flush_cnt_reg + CW'(1);
    end
  end

  assign stall_cnt = stall_cnt_reg;
  assign flush_cnt = flush_cnt_reg;

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Randomised and directed bench for pipe_hazard_unit: a forwarding build and a
// no-forward build share stimulus and are each compared to a list-of-producers model.
module tb_pipe_hazard_unit;
  localparam int RW = 5, DEPTH = 3, LOAD_LAT = 2, BR_STAGE = 3, CW = 16;
  localparam int CMAX = (1 << CW) - 1;

  typedef struct {int stage; int wn; bit ld;} prod_t;
  typedef prod_t pq_t[$];

  logic clk = 1'b0, clr;
  logic id_valid, id_use_rs, id_use_rt, id_wreg, id_m2reg, br_taken;
  logic [RW-1:0] id_rs, id_rt, id_wn;
  logic stall, bubble, flush, stall0, bubble0, flush0;
  logic [1:0] fwd_a, fwd_b, fwd_a0, fwd_b0;
  logic [CW-1:0] stall_cnt, flush_cnt, stall_cnt0, flush_cnt0;

  int n_cmp = 0, n_err = 0;
  pq_t q1, q0;
  int sc1 = 0, fc1 = 0, sc0 = 0, fc0 = 0;

  always #5 clk = ~clk;

  pipe_hazard_unit #(.RW(RW), .DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT), .BR_STAGE(BR_STAGE),
                     .FWD_EN(1), .CW(CW)) dut (
    .clk(clk), .clr(clr), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wreg(id_wreg), .id_m2reg(id_m2reg),
    .id_wn(id_wn), .br_taken(br_taken), .stall(stall), .bubble(bubble), .flush(flush),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));

  pipe_hazard_unit #(.RW(RW), .DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT), .BR_STAGE(BR_STAGE),
                     .FWD_EN(0), .CW(CW)) dut0 (
    .clk(clk), .clr(clr), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wreg(id_wreg), .id_m2reg(id_m2reg),
    .id_wn(id_wn), .br_taken(br_taken), .stall(stall0), .bubble(bubble0), .flush(flush0),
    .fwd_a(fwd_a0), .fwd_b(fwd_b0), .stall_cnt(stall_cnt0), .flush_cnt(flush_cnt0));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Nearest (smallest stage) producer of src decides the operand outcome.
  function automatic void opnd(input pq_t q, input int src, input bit use_src, input bit fen,
                               output bit st, output int fw);
    int best = DEPTH + 1;
    bit ld = 1'b0;
    if (id_valid && use_src && src != 0)
      foreach (q[i]) if (q[i].wn == src && q[i].stage < best) begin
        best = q[i].stage;
        ld   = q[i].ld;
      end
    if (best > DEPTH) begin
      st = 1'b0;
      fw = 0;
    end else begin
      st = !fen || (ld && best < LOAD_LAT);
      fw = (fen && !st) ? best : 0;
    end
  endfunction

  function automatic pq_t advance(input pq_t q, input bit held);
    pq_t n;
    prod_t p;
    if (clr) return n;
    foreach (q[i]) begin
      p = q[i];
      if (!(br_taken && p.stage < BR_STAGE)) begin
        p.stage++;
        if (p.stage <= DEPTH) n.push_back(p);
      end
    end
    if (id_valid && id_wreg && !held && !br_taken) begin
      p.stage = 1; p.wn = int'(id_wn); p.ld = id_m2reg;
      n.push_back(p);
    end
    return n;
  endfunction

  function automatic int bump(input int c, input bit inc);
    return (inc && c < CMAX) ? c + 1 : c;
  endfunction

  task automatic set_id(input bit v, input int rs, input int rt, input bit urs, input bit urt,
                        input bit wr, input bit ld, input int wn, input bit br);
    id_valid = v; id_rs = RW'(rs); id_rt = RW'(rt); id_use_rs = urs; id_use_rt = urt;
    id_wreg = wr; id_m2reg = ld; id_wn = RW'(wn); br_taken = br;
  endtask

  task automatic cyc(input bit chk);
    bit sa, sb, s0a, s0b, st1, st0;
    int fa, fb, f0a, f0b;
    @(negedge clk);
    opnd(q1, int'(id_rs), id_use_rs, 1'b1, sa, fa);
    opnd(q1, int'(id_rt), id_use_rt, 1'b1, sb, fb);
    opnd(q0, int'(id_rs), id_use_rs, 1'b0, s0a, f0a);
    opnd(q0, int'(id_rt), id_use_rt, 1'b0, s0b, f0b);
    st1 = sa || sb;
    st0 = s0a || s0b;
    if (chk) begin
      check("stall", stall, st1 && !br_taken);
      check("bubble", bubble, st1 || br_taken);
      check("flush", flush, br_taken);
      check("fwd_a", fwd_a, fa);
      check("fwd_b", fwd_b, fb);
      check("stall_cnt", stall_cnt, sc1);
      check("flush_cnt", flush_cnt, fc1);
      check("stall0", stall0, st0 && !br_taken);
      check("bubble0", bubble0, st0 || br_taken);
      check("flush0", flush0, br_taken);
      check("fwd_a0", fwd_a0, f0a);
      check("fwd_b0", fwd_b0, f0b);
      check("stall_cnt0", stall_cnt0, sc0);
      check("flush_cnt0", flush_cnt0, fc0);
    end
    @(posedge clk);
    q1 = advance(q1, st1);
    q0 = advance(q0, st0);
    sc1 = clr ? 0 : bump(sc1, st1 && !br_taken);
    fc1 = clr ? 0 : bump(fc1, br_taken);
    sc0 = clr ? 0 : bump(sc0, st0 && !br_taken);
    fc0 = clr ? 0 : bump(fc0, br_taken);
    #1;
  endtask

  initial begin
    clr = 1'b1;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0); cyc(0);
    clr = 1'b0;

    // Reset state
    set_id(1, 3, 4, 1, 1, 0, 0, 0, 0); #2;
    check("rst_stall", stall, 0); check("rst_fwd_a", fwd_a, 0); check("rst_fwd_b", fwd_b, 0);
    check("rst_scnt", stall_cnt, 0); check("rst_fcnt", flush_cnt, 0);
    cyc(1);

    // ALU chain
    set_id(1, 1, 2, 1, 1, 1, 0, 5, 0); cyc(1);
    set_id(1, 5, 5, 1, 1, 1, 0, 6, 0); #2;
    check("alu_fwd_a", fwd_a, 1); check("alu_fwd_b", fwd_b, 1); check("alu_stall", stall, 0);
    cyc(1);
    set_id(1, 5, 0, 1, 0, 0, 0, 0, 0); #2;
    check("alu_fwd2", fwd_a, 2);
    cyc(1);

    // Load-use
    set_id(1, 1, 0, 1, 0, 1, 1, 7, 0); cyc(1);
    set_id(1, 7, 0, 1, 0, 0, 0, 0, 0); #2;
    check("lu_stall", stall, 1); check("lu_bubble", bubble, 1);
    cyc(1); #2;
    check("lu_stall_after", stall, 0); check("lu_fwd", fwd_a, 2); check("lu_scnt", stall_cnt, 1);
    cyc(1);

    // Youngest producer wins; r0 never matches
    set_id(1, 0, 0, 0, 0, 1, 0, 9, 0); cyc(1);
    set_id(1, 0, 0, 0, 0, 0, 0, 0, 0); cyc(1);
    set_id(1, 0, 0, 0, 0, 1, 0, 9, 0); cyc(1);
    set_id(1, 9, 9, 1, 1, 0, 0, 0, 0); #2;
    check("yw_fwd_a", fwd_a, 1); check("yw_fwd_b", fwd_b, 1);
    cyc(1);
    set_id(1, 0, 0, 0, 0, 1, 0, 0, 0); cyc(1);
    set_id(1, 0, 0, 1, 1, 0, 0, 0, 0); #2;
    check("r0_fwd", fwd_a, 0); check("r0_stall", stall, 0);
    cyc(1);

    // Flush beats a pending load-use stall
    set_id(1, 0, 0, 0, 0, 1, 0, 11, 0); cyc(1);
    set_id(1, 0, 0, 0, 0, 1, 1, 10, 0); cyc(1);
    set_id(1, 10, 0, 1, 0, 0, 0, 0, 1); #2;
    check("fl_flush", flush, 1); check("fl_stall", stall, 0); check("fl_bubble", bubble, 1);
    cyc(1);
    set_id(1, 10, 10, 1, 1, 0, 0, 0, 0); #2;
    check("fl_killed_a", fwd_a, 0); check("fl_killed_st", stall, 0); check("fl_fcnt", flush_cnt, 1);
    cyc(1);

    // No-forward build holds the reader until the producer retires
    clr = 1'b1; set_id(0, 0, 0, 0, 0, 0, 0, 0, 0); cyc(1);
    clr = 1'b0;
    set_id(1, 1, 2, 1, 1, 1, 0, 5, 0); cyc(1);
    set_id(1, 5, 0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      #2; check("nf_stall", stall0, 1); check("nf_fwd", fwd_a0, 0);
      cyc(1);
    end
    #2; check("nf_release", stall0, 0); check("nf_fwd_end", fwd_a0, 0);
    cyc(1);

    // Random traffic over a small register set to provoke hazards
    for (int i = 0; i < 600; i++) begin
      bit v;
      clr = ($urandom_range(0, 49) == 0);
      v = ($urandom_range(0, 7) != 0);
      set_id(v, $urandom_range(0, 7), $urandom_range(0, 7),
             v && ($urandom_range(0, 3) != 0), v && ($urandom_range(0, 1) != 0),
             $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
             $urandom_range(0, 7), $urandom_range(0, 7) == 0);
      cyc(1);
    end
    clr = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
